// File: rtl/types_pkg.sv
// +--------------------------------------------------------------------+
// | types_pkg : shared constants and payload types for pipe_chain      |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
`default_nettype none

package types_pkg;
   localparam int DEFAULT_STAGES = 4;
   localparam int DEFAULT_CNT_W  = 32;
   localparam int WORD_W         = 32;

   typedef logic [WORD_W-1:0] word_t;
endpackage

`default_nettype wire

// File: rtl/pipe_chain_if.sv
// +--------------------------------------------------------------------+
// | pipe_chain_if : input handshake, per-stage controls and observation |
// | Revision      : 1.0                                                 |
// +--------------------------------------------------------------------+
`default_nettype none

interface pipe_chain_if #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4,
   parameter int CNT_W  = 32
);
   logic                           in_valid;
   logic [WIDTH-1:0]               in_data;
   logic                           in_ready;
   logic [STAGES-1:0]              stall;
   logic [STAGES-1:0]              flush;
   logic [STAGES-1:0]              stage_valid;
   logic [STAGES-1:0][WIDTH-1:0]   stage_data;
   logic                           out_valid;
   logic [WIDTH-1:0]               out_data;
   logic [CNT_W-1:0]               retire_count;
   logic [CNT_W-1:0]               bubble_count;

   modport master (
      output in_valid, in_data, stall, flush,
      input  in_ready, stage_valid, stage_data, out_valid, out_data,
             retire_count, bubble_count
   );

   modport slave (
      input  in_valid, in_data, stall, flush,
      output in_ready, stage_valid, stage_data, out_valid, out_data,
             retire_count, bubble_count
   );
endinterface

`default_nettype wire

// File: rtl/pipe_stage.sv
// +--------------------------------------------------------------------+
// | pipe_stage : one valid+data register, priority flush > hold > load  |
// | Revision   : 1.0                                                    |
// +--------------------------------------------------------------------+
`default_nettype none

module pipe_stage #(
   parameter int WIDTH = 32
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             flush_i,
   input  wire logic             hold_i,
   input  wire logic             valid_i,
   input  wire logic [WIDTH-1:0] data_i,
   output logic                  valid_o,
   output logic [WIDTH-1:0]      data_o
);

   logic             valid_q;
   logic             valid_d;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush_i) begin
         valid_d = 1'b0;
         data_d  = '0;
      end else if (!hold_i) begin
         valid_d = valid_i;
         data_d  = data_i;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

`default_nettype wire

// File: rtl/pipe_chain.sv
// +--------------------------------------------------------------------+
// | pipe_chain : stallable/flushable register pipeline with counters    |
// | Revision   : 1.0                                                    |
// +--------------------------------------------------------------------+
`default_nettype none

module pipe_chain
   import types_pkg::*;
#(
   parameter int WIDTH    = WORD_W,
   parameter int STAGES   = DEFAULT_STAGES,
   parameter int COLLAPSE = 0,
   parameter int CNT_W    = DEFAULT_CNT_W
) (
   input  wire logic     clk,
   input  wire logic     reset,
   pipe_chain_if.slave   bus
);

   logic [STAGES-1:0]            hold;
   logic [STAGES-1:0]            stage_valid;
   logic [STAGES-1:0][WIDTH-1:0] stage_data;
   logic [STAGES-1:0]            load_valid;
   logic [STAGES-1:0][WIDTH-1:0] load_data;

   logic [CNT_W-1:0]             retire_q;
   logic [CNT_W-1:0]             retire_d;
   logic [CNT_W-1:0]             bubble_q;
   logic [CNT_W-1:0]             bubble_d;

   // Hold ripples backwards from the output; in collapse mode an empty stage
   // breaks the chain so upstream data can fill it.
   always_comb begin
      logic h;
      h    = 1'b0;
      hold = '0;
      for (int i = STAGES - 1; i >= 0; i--) begin
         h       = (bus.stall[i] | h) & ((COLLAPSE != 0) ? stage_valid[i] : 1'b1);
         hold[i] = h;
      end
   end

   always_comb begin
      load_valid    = '0;
      load_data     = '0;
      load_valid[0] = bus.in_valid;
      load_data[0]  = bus.in_data;
      for (int i = 1; i < STAGES; i++) begin
         load_valid[i] = stage_valid[i-1] & ~hold[i-1];
         load_data[i]  = stage_data[i-1];
      end
   end

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      pipe_stage #(
         .WIDTH   (WIDTH)
      ) u_stage (
         .clk     (clk),
         .reset   (reset),
         .flush_i (bus.flush[gi]),
         .hold_i  (hold[gi]),
         .valid_i (load_valid[gi]),
         .data_i  (load_data[gi]),
         .valid_o (stage_valid[gi]),
         .data_o  (stage_data[gi])
      );
   end

   always_comb begin
      retire_d = retire_q;
      bubble_d = bubble_q;
      if (stage_valid[STAGES-1] && !hold[STAGES-1] && (retire_q != '1)) begin
         retire_d = retire_q + CNT_W'(1);
      end
      if (!stage_valid[STAGES-1] && (bubble_q != '1)) begin
         bubble_d = bubble_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retire_q <= '0;
         bubble_q <= '0;
      end else begin
         retire_q <= retire_d;
         bubble_q <= bubble_d;
      end
   end

   assign bus.in_ready     = ~hold[0];
   assign bus.stage_valid  = stage_valid;
   assign bus.stage_data   = stage_data;
   assign bus.out_valid    = stage_valid[STAGES-1];
   assign bus.out_data     = stage_data[STAGES-1];
   assign bus.retire_count = retire_q;
   assign bus.bubble_count = bubble_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_chain.sv
// +--------------------------------------------------------------------+
// | tb_pipe_chain : directed checks of pipe_chain in three configs      |
// | Revision      : 1.0                                                 |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_pipe_chain;
   import types_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   word_t      in_data = '0;
   logic [3:0] stall = '0;
   logic [3:0] flush = '0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipe_chain_if #(.WIDTH($bits(word_t)), .STAGES(4), .CNT_W(32)) if_m ();
   pipe_chain_if #(.WIDTH($bits(word_t)), .STAGES(4), .CNT_W(32)) if_c ();
   pipe_chain_if #(.WIDTH($bits(word_t)), .STAGES(4), .CNT_W(4))  if_s ();

   assign if_m.in_valid = in_valid;
   assign if_m.in_data  = in_data;
   assign if_m.stall    = stall;
   assign if_m.flush    = flush;
   assign if_c.in_valid = in_valid;
   assign if_c.in_data  = in_data;
   assign if_c.stall    = stall;
   assign if_c.flush    = flush;
   assign if_s.in_valid = in_valid;
   assign if_s.in_data  = in_data;
   assign if_s.stall    = stall;
   assign if_s.flush    = flush;

   pipe_chain #(.WIDTH($bits(word_t)), .STAGES(DEFAULT_STAGES), .COLLAPSE(0), .CNT_W(32))
      u_main (.clk(clk), .reset(reset), .bus(if_m));
   pipe_chain #(.WIDTH($bits(word_t)), .STAGES(DEFAULT_STAGES), .COLLAPSE(1), .CNT_W(32))
      u_col  (.clk(clk), .reset(reset), .bus(if_c));
   pipe_chain #(.WIDTH($bits(word_t)), .STAGES(DEFAULT_STAGES), .COLLAPSE(0), .CNT_W(4))
      u_sat  (.clk(clk), .reset(reset), .bus(if_s));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      stall    = '0;
      flush    = '0;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      // Reset state
      step();
      step();
      chk("rst_stage_valid", 64'(if_m.stage_valid), 64'h0);
      chk("rst_out_data",    64'(if_m.out_data),    64'h0);
      chk("rst_in_ready",    64'(if_m.in_ready),    64'h1);
      chk("rst_retire",      64'(if_m.retire_count), 64'h0);
      chk("rst_bubble",      64'(if_m.bubble_count), 64'h0);
      reset = 1'b0;

      // Free-running stream 1..8, latency 4
      for (int k = 1; k <= 12; k++) begin
         in_valid = (k <= 8);
         in_data  = word_t'(k);
         step();
         if (k >= 4 && k <= 11) begin
            chk("stream_out_valid", 64'(if_m.out_valid), 64'h1);
            chk("stream_out_data",  64'(if_m.out_data),  64'(k - 3));
         end
         if (k == 8) chk("stream_retire_mid", 64'(if_m.retire_count), 64'd4);
      end
      chk("stream_retire_end", 64'(if_m.retire_count), 64'd8);
      chk("stream_drained",    64'(if_m.out_valid),    64'h0);

      // Stall stage 1 for two cycles
      do_reset();
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1;
         in_data  = word_t'(10 * (k + 1));
         step();
      end
      chk("stall_out10", 64'(if_m.out_data), 64'd10);
      in_valid = 1'b0;
      stall    = 4'b0010;
      #1;
      chk("stall_in_ready", 64'(if_m.in_ready), 64'h0);
      step();
      chk("stall_valid_e5", 64'(if_m.stage_valid),   64'b1011);
      chk("stall_s0_hold",  64'(if_m.stage_data[0]), 64'd40);
      chk("stall_s1_hold",  64'(if_m.stage_data[1]), 64'd30);
      chk("stall_out20",    64'(if_m.out_data),      64'd20);
      step();
      chk("stall_valid_e6", 64'(if_m.stage_valid),   64'b0011);
      stall = 4'b0000;
      step();
      chk("stall_valid_e7", 64'(if_m.stage_valid),   64'b0110);
      step();
      chk("stall_out30_v",  64'(if_m.out_valid),     64'h1);
      chk("stall_out30",    64'(if_m.out_data),      64'd30);
      step();
      chk("stall_out40",    64'(if_m.out_data),      64'd40);
      step();
      chk("stall_retire",   64'(if_m.retire_count),  64'd4);

      // Flush and stall together on stage 1
      do_reset();
      in_valid = 1'b1;
      in_data  = word_t'(32'hAA);
      step();
      in_valid = 1'b0;
      step();
      chk("flush_pre_data", 64'(if_m.stage_data[1]), 64'hAA);
      stall = 4'b0010;
      flush = 4'b0010;
      step();
      stall = 4'b0000;
      flush = 4'b0000;
      chk("flush_s1_valid", 64'(if_m.stage_valid[1]), 64'h0);
      chk("flush_s1_data",  64'(if_m.stage_data[1]),  64'h0);
      chk("flush_all_valid", 64'(if_m.stage_valid),   64'h0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("flush_no_out", 64'(if_m.out_valid), 64'h0);
      end
      chk("flush_retire", 64'(if_m.retire_count), 64'h0);

      // Flush of stage 1 while it advances into stage 2
      do_reset();
      in_valid = 1'b1;
      in_data  = word_t'(32'h55);
      step();
      in_valid = 1'b0;
      step();
      flush = 4'b0010;
      step();
      flush = 4'b0000;
      chk("fadv_valid",  64'(if_m.stage_valid),   64'b0100);
      chk("fadv_s2",     64'(if_m.stage_data[2]), 64'h55);
      step();
      chk("fadv_out",    64'(if_m.out_data),      64'h55);

      // Collapse vs hold-all with output stalled
      do_reset();
      in_valid = 1'b1;
      in_data  = word_t'(32'h77);
      step();
      in_valid = 1'b0;
      step();
      step();
      step();
      chk("col_only_s3_c", 64'(if_c.stage_valid), 64'b1000);
      chk("col_only_s3_m", 64'(if_m.stage_valid), 64'b1000);
      stall = 4'b1000;
      #1;
      chk("col_ready_m0", 64'(if_m.in_ready), 64'h0);
      chk("col_ready_c0", 64'(if_c.in_ready), 64'h1);
      for (int k = 1; k <= 3; k++) begin
         in_valid = 1'b1;
         in_data  = word_t'(k);
         step();
         chk("col_ready_fill", 64'(if_c.in_ready), (k < 3) ? 64'h1 : 64'h0);
      end
      chk("col_full_valid", 64'(if_c.stage_valid),   64'b1111);
      chk("col_s0",         64'(if_c.stage_data[0]), 64'd3);
      chk("col_s1",         64'(if_c.stage_data[1]), 64'd2);
      chk("col_s2",         64'(if_c.stage_data[2]), 64'd1);
      chk("col_s3",         64'(if_c.stage_data[3]), 64'h77);
      in_data = word_t'(4);
      step();
      chk("col_not_captured", 64'(if_c.stage_data[0]), 64'd3);
      chk("col_m_held",       64'(if_m.stage_valid),   64'b1000);
      chk("col_m_out",        64'(if_m.out_data),      64'h77);
      chk("col_no_retire",    64'(if_c.retire_count),  64'h0);
      stall    = 4'b0000;
      in_valid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk("col_drain_data", 64'(if_c.out_data), 64'(k));
      end
      chk("col_retire", 64'(if_c.retire_count), 64'd3);

      // Counter saturation with a 4-bit counter
      do_reset();
      for (int n = 1; n <= 20; n++) begin
         step();
         if (n == 10) chk("sat_bubble_10", 64'(if_s.bubble_count), 64'd10);
         if (n == 15) chk("sat_bubble_15", 64'(if_s.bubble_count), 64'd15);
         if (n == 16) chk("sat_no_wrap",   64'(if_s.bubble_count), 64'd15);
      end
      chk("sat_bubble_20", 64'(if_s.bubble_count), 64'd15);
      chk("sat_wide_20",   64'(if_m.bubble_count), 64'd20);
      chk("sat_retire",    64'(if_s.retire_count), 64'h0);

      // Half-cycle reset pulse with three items in flight
      do_reset();
      in_valid = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         in_data = word_t'(32'h10 + k);
         step();
      end
      in_valid = 1'b0;
      chk("mid_inflight", 64'(if_m.stage_valid), 64'b0111);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_async_valid",  64'(if_m.stage_valid),  64'h0);
      chk("mid_async_bubble", 64'(if_m.bubble_count), 64'h0);
      chk("mid_async_data",   64'(if_m.stage_data[2]), 64'h0);
      #2;
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         chk("mid_no_stale", 64'(if_m.out_valid), 64'h0);
      end
      chk("mid_bubble_after", 64'(if_m.bubble_count), 64'd6);
      chk("mid_retire_after", 64'(if_m.retire_count), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
